// File: rtl/square.sv
// square: sequential unsigned squarer, radix-2 shift-and-add.
//
// One multiplier bit is consumed per clock, so a result takes exactly WIDTH
// cycles after the accepting edge, regardless of the operand value. The full
// 2*WIDTH product is accumulated; out carries the low half and overflow flags
// a nonzero high half.
//
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset, clears all state
//   go        start request, honoured only while idle
//   in        WIDTH-bit unsigned operand, captured on the accepting edge
//   out       low WIDTH bits of in*in, held until the next result
//   overflow  high WIDTH bits of in*in are nonzero, updates with out
//   done      result valid, held until the next start is accepted
module square #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic               running;
  logic [IW-1:0]      idx;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  logic               start;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0]   mplier_next;

  assign start = go && !running;

  // The accumulator is 2*WIDTH wide, which always holds a square exactly,
  // so no carry is lost before the overflow test.
  always_comb begin
    acc_next    = acc + (mplier[0] ? mcand : '0);
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      idx      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      out      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      done    <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, in};
      mplier  <= in;
    end else if (running) begin
      if (idx == LAST) begin
        // Final iteration: publish straight from the combinational sum;
        // the working registers are left as they are.
        out      <= acc_next[WIDTH-1:0];
        overflow <= |acc_next[2*WIDTH-1:WIDTH];
        done     <= 1'b1;
        running  <= 1'b0;
      end else begin
        acc    <= acc_next;
        mcand  <= mcand_next;
        mplier <= mplier_next;
        idx    <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_square.sv
module tb_square;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         go;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic         overflow;
  logic         done;

  square #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .in(in),
    .out(out), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] op;
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Integer square root by bit-wise search, used for the sqrt round trip.
  function automatic logic [63:0] isqrt(input logic [63:0] v);
    logic [63:0] r, t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input int due);
    exp_t e;
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, a};
    e.op  = a;
    e.res = p[31:0];
    e.ovf = (p[63:32] != 0);
    e.due = due;
    return e;
  endfunction

  // Monitor: each rising done retires one scoreboard entry.
  always @(negedge clk) begin
    if (!reset_n) done_prev <= 1'b0;
    else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", out, e.res);
          chk("overflow", overflow, e.ovf);
          chk("latency_cycle", cyc, e.due);
          if (!e.ovf) chk("sqrt_roundtrip", isqrt({32'd0, out}), e.op);
        end
      end
      done_prev <= done;
    end
  end

  // Wait on the accepting edge and record the expected result.
  task automatic accept(input logic [W-1:0] a);
    @(posedge clk);
    #1;
    sb.push_back(model(a, cyc + W));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3 * W) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_one(input logic [W-1:0] a);
    @(negedge clk);
    go = 1'b1;
    in = a;
    accept(a);
    @(negedge clk);
    go = 1'b0;
    in = $urandom;  // post-accept operand changes must not matter
    wait_drain();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    go = 1'b0;
    in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed operands.
    run_one(32'd0);
    run_one(32'd65535);
    run_one(32'd46341);
    run_one(32'd65536);
    run_one(32'hFFFFFFFF);
    run_one(32'd1);

    // go while running is ignored.
    @(negedge clk);
    go = 1'b1;
    in = 32'd7;
    accept(32'd7);
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    go = 1'b1;
    in = 32'd9;
    @(negedge clk);
    go = 1'b0;
    wait_drain();
    run_one(32'd9);

    // go held high: back-to-back runs, done high for a single cycle.
    @(negedge clk);
    go = 1'b1;
    in = 32'd3;
    accept(32'd3);
    in = 32'd5;
    begin
      int n;
      n = 0;
      while (!done && n < 3 * W) begin
        @(negedge clk);
        n++;
      end
      chk("held_first_done", done, 1);
    end
    accept(32'd5);
    @(negedge clk);
    chk("held_done_one_cycle", done, 0);
    go = 1'b0;
    wait_drain();

    // Randomized operands, half kept small so the round trip applies.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a;
      a = (i % 2 == 0) ? W'($urandom_range(0, 65535)) : W'($urandom);
      run_one(a);
    end

    // Reset mid-run aborts without a done pulse.
    @(negedge clk);
    go = 1'b1;
    in = 32'd1000;
    accept(32'd1000);
    @(negedge clk);
    go = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_done", done, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_abort", done, 0);
    run_one(32'd12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
